ps2_event_rx: RTL and testbench
===============================

// Module: ps2_event_rx
// PURPOSE
//  PS/2 keyboard receiver: frame capture, prefix decoding (E0 extended, F0 break) and event queueing.
//  Each complete key event {ext,brk,code} goes into a parametrised FIFO with a valid/ready pop interface.
//  Also tracks modifier and CapsLock state.
//  Sits between the PS/2 pins and the scancode-to-ASCII / console logic.
// PARAMETERS
//  FIFO_DEPTH      8      event FIFO entries; power of 2, >=2
//  SYNC_STAGES     3      ps2_clk/ps2_data synchroniser depth, >=2
//  TIMEOUT_CYCLES  50000  clk cycles without a ps2_clk falling edge mid-frame before the bit counter resyncs
// PORTS
//  clk        in   1   system clock
//  clrn       in   1   asynchronous active-low reset
//  ps2_clk    in   1   PS/2 clock pin (async)
//  ps2_data   in   1   PS/2 data pin (async)
//  ev_valid   out  1   FIFO not empty
//  ev_ready   in   1   consumer accepts head event
//  ev_code    out  8   head event scancode (final byte)
//  ev_ext     out  1   head event had E0 prefix
//  ev_brk     out  1   head event had F0 prefix (key release)
//  mods       out  4   {caps_lock, alt, ctrl, shift}, live decoder state
//  level      out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
//  overflow   out  1   sticky: event dropped on full FIFO
//  frame_err  out  1   1-cycle pulse: bad start/parity/stop, or timeout
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, decoder IDLE, bit count 0, internal held-key bits 0.
//  Frame: sample ps2_data on synchronised ps2_clk falling edge.
//  - 11 bits, LSB first; valid = start 0, odd parity over data+parity, stop 1.
//  - Invalid frame: byte discarded, frame_err pulses, count back to 0.
//  - Count !=0 and TIMEOUT_CYCLES with no falling edge: count back to 0, frame_err pulses.
//  Decoder FSM, one byte per cycle:
//  - IDLE: E0->EXT, F0->BRK, 00/FF discarded, other -> emit {0,0,b}.
//  - EXT: F0->EXTBRK, E0 ignored, other -> emit {1,0,b}.
//  - BRK: other -> emit {0,1,b}.
//  - EXTBRK: other -> emit {1,1,b}.
//  - Every emit returns to IDLE.
//  - E0/F0 received in BRK or EXTBRK: restart at EXT/BRK accordingly.
//  Modifiers: updated when the event is emitted, not when it is popped.
//  - Held bits: LShift 12, RShift 59, LCtrl 14, RCtrl E0 14, LAlt 11, RAlt E0 11.
//  - shift/ctrl/alt = OR of the L and R held bits.
//  - caps_lock toggles on a make of 58 only if 58 is not already held; repeats do not toggle.
//  - Modifier events are still pushed to the FIFO.
//  Latency: byte complete at stop-bit edge cycle T -> decoder at T+1 -> ev_valid at T+2 (empty FIFO).
//  FIFO is show-ahead; ev_* are valid combinationally from the head while ev_valid=1.
//  - Pop on ev_valid & ev_ready.
//  - Push when full with no pop: event dropped, overflow set until reset.
//  - Push and pop in same cycle while full: both happen, no overflow.
//  - Pop when empty: ignored.
//  - Pointers wrap modulo FIFO_DEPTH.
//  clrn low mid-frame or mid-prefix: everything aborts immediately; a partial frame on release
//  is rejected by the start/parity/stop check or the timeout.
// CONFIGURATION
//  PS2_REPEAT_FILTER_EN defined: a make whose {ext,code} equals the last pushed make is not pushed,
//  provided no break of that key has occurred since. Typematic repeats are suppressed; modifiers unaffected.
//  Undefined: every make event is pushed.
// STRUCTURE
//  Package ps2_pkg holds:
//  - scancode constants PS2_E0, PS2_F0, LSHIFT, RSHIFT, CTRL, ALT, CAPS
//  - decoder state enum {IDLE, EXT, BRK, EXTBRK}
//  - event width constant (10)
//  Sub-module ps2_frame_rx: synchroniser, edge detect, bit counter, timeout, validity check.
//  - Outputs byte + byte_valid pulse + frame_err.
// TESTING
//  1. Send 1C; then F0 1C -> events {0,0,1C} and {0,1,1C}; ev_valid 2 cycles after each stop edge.
//  2. Send E0 14, then E0 F0 14 -> {1,0,14} then {1,1,14}; mods[1] goes 1 then 0; LCtrl held bit untouched.
//  3. 58 sent 3x, then F0 58, then 58 -> caps_lock=1 after first make, stays 1 through repeats, 0 after second make.
//  4. ev_ready=0, FIFO_DEPTH+1 makes -> level=FIFO_DEPTH, overflow=1, first FIFO_DEPTH codes popped in order.
//  5. Frame with bad parity, then a half frame followed by idle > TIMEOUT_CYCLES, then 1C -> 2 frame_err pulses, only {0,0,1C} queued.
//  6. 1C 1C 1C with PS2_REPEAT_FILTER_EN -> 1 event; without the macro -> 3 events.

Source files
------------

// File: rtl/ps2_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ps2_pkg                                                         |
// | Purpose  : Shared constants and types for the PS/2 keyboard receiver:      |
// |            scancode constants, decoder state encoding, key event layout.   |
// | Ports    : none (package)                                                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package ps2_pkg;

  localparam logic [7:0] PS2_E0 = 8'hE0;  // extended-key prefix
  localparam logic [7:0] PS2_F0 = 8'hF0;  // break (release) prefix
  localparam logic [7:0] LSHIFT = 8'h12;
  localparam logic [7:0] RSHIFT = 8'h59;
  localparam logic [7:0] CTRL   = 8'h14;  // left without E0, right with E0
  localparam logic [7:0] ALT    = 8'h11;  // left without E0, right with E0
  localparam logic [7:0] CAPS   = 8'h58;

  localparam int EV_W = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXT    = 2'd1,
    BRK    = 2'd2,
    EXTBRK = 2'd3
  } dec_state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_event_t;

endpackage
`default_nettype wire

// File: rtl/ps2_frame_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ps2_frame_rx                                                    |
// | Purpose  : PS/2 frame capture. Synchronises the pins, samples data on each |
// |            ps2_clk falling edge, checks start/parity/stop and resyncs the  |
// |            bit counter after a mid-frame stall.                            |
// | Ports    : clk, clrn (async active-low) ; ps2_clk, ps2_data (async pins)   |
// |            rx_byte[7:0], byte_valid (1-cycle), frame_err (1-cycle)         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module ps2_frame_rx #(
  parameter int SYNC_STAGES    = 3,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int            TW         = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] C_TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_data_sync;
  logic                   r_clk_prev;
  logic [3:0]             r_cnt;
  logic [9:0]             r_shift;
  logic [TW-1:0]          r_tmo;
  logic [7:0]             r_byte;
  logic                   r_byte_valid;
  logic                   r_frame_err;

  logic w_clk_s, w_data_s, w_fall, w_frame_ok;

  assign w_clk_s  = r_clk_sync[SYNC_STAGES-1];
  assign w_data_s = r_data_sync[SYNC_STAGES-1];
  assign w_fall   = r_clk_prev & ~w_clk_s;

  // After ten shifts: [0]=start, [8:1]=data LSB first, [9]=parity.
  // The stop bit is the sample arriving on the eleventh edge.
  assign w_frame_ok = ~r_shift[0] & (^r_shift[9:1]) & w_data_s;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_clk_sync   <= '0;
      r_data_sync  <= '0;
      r_clk_prev   <= 1'b0;
      r_cnt        <= 4'd0;
      r_shift      <= '0;
      r_tmo        <= '0;
      r_byte       <= 8'd0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_clk_sync   <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
      r_data_sync  <= {r_data_sync[SYNC_STAGES-2:0], ps2_data};
      r_clk_prev   <= w_clk_s;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      if (w_fall) begin
        r_tmo <= '0;
        if (r_cnt == 4'd10) begin
          r_cnt <= 4'd0;
          if (w_frame_ok) begin
            r_byte       <= r_shift[8:1];
            r_byte_valid <= 1'b1;
          end else begin
            r_frame_err  <= 1'b1;
          end
        end else begin
          r_cnt   <= r_cnt + 4'd1;
          r_shift <= {w_data_s, r_shift[9:1]};
        end
      end else if (r_cnt != 4'd0) begin
        // Stalled mid-frame: drop the partial frame so the next start bit lines up.
        if (r_tmo == C_TMO_LAST) begin
          r_cnt       <= 4'd0;
          r_tmo       <= '0;
          r_frame_err <= 1'b1;
        end else begin
          r_tmo <= r_tmo + 1'b1;
        end
      end else begin
        r_tmo <= '0;
      end
    end
  end

  assign rx_byte    = r_byte;
  assign byte_valid = r_byte_valid;
  assign frame_err  = r_frame_err;

endmodule
`default_nettype wire

// File: rtl/ps2_event_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ps2_event_rx                                                    |
// | Purpose  : PS/2 keyboard receiver. Decodes E0/F0 prefixes into key events  |
// |            {ext,brk,code}, queues them in a show-ahead FIFO with a         |
// |            valid/ready pop port, and tracks modifier / CapsLock state.     |
// | Ports    : clk, clrn (async active-low), ps2_clk, ps2_data (async pins)    |
// |            ev_valid/ev_ready, ev_code[7:0], ev_ext, ev_brk : event port    |
// |            mods[3:0] = {caps_lock, alt, ctrl, shift}                       |
// |            level = FIFO occupancy, overflow (sticky), frame_err (pulse)    |
// | Config   : PS2_REPEAT_FILTER_EN - suppress typematic repeats of the last   |
// |            pushed make until that key is released.                         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module ps2_event_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int SYNC_STAGES    = 3,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                        clk,
  input  logic                        clrn,
  input  logic                        ps2_clk,
  input  logic                        ps2_data,
  output logic                        ev_valid,
  input  logic                        ev_ready,
  output logic [7:0]                  ev_code,
  output logic                        ev_ext,
  output logic                        ev_brk,
  output logic [3:0]                  mods,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        overflow,
  output logic                        frame_err
);

  localparam int          AW     = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] C_FULL = (AW + 1)'(FIFO_DEPTH);

  logic [7:0] rx_byte;
  logic       byte_valid;

  ps2_frame_rx #(
    .SYNC_STAGES    (SYNC_STAGES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_frame_rx (
    .clk        (clk),
    .clrn       (clrn),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .frame_err  (frame_err)
  );

  // ---------------- prefix decoder ----------------
  dec_state_t r_state, w_state_nxt;
  logic       w_emit;
  ps2_event_t w_ev;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_emit      = 1'b0;
    w_ev.ext    = 1'b0;
    w_ev.brk    = 1'b0;
    w_ev.code   = rx_byte;
    if (byte_valid) begin
      case (r_state)
        IDLE: begin
          if (rx_byte == PS2_E0)      w_state_nxt = EXT;
          else if (rx_byte == PS2_F0) w_state_nxt = BRK;
          else if (rx_byte != 8'h00 && rx_byte != 8'hFF) w_emit = 1'b1;
        end
        EXT: begin
          if (rx_byte == PS2_F0)      w_state_nxt = EXTBRK;
          else if (rx_byte != PS2_E0) begin
            w_emit   = 1'b1;
            w_ev.ext = 1'b1;
          end
        end
        BRK, EXTBRK: begin
          // A fresh prefix inside a break sequence restarts the sequence.
          if (rx_byte == PS2_E0)      w_state_nxt = EXT;
          else if (rx_byte == PS2_F0) w_state_nxt = BRK;
          else begin
            w_emit   = 1'b1;
            w_ev.ext = (r_state == EXTBRK);
            w_ev.brk = 1'b1;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
      if (w_emit) w_state_nxt = IDLE;
    end
  end

  // ---------------- modifier tracking ----------------
  logic r_lshift, r_rshift, r_lctrl, r_rctrl, r_lalt, r_ralt;
  logic r_caps_held, r_caps_lock;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_lshift    <= 1'b0;
      r_rshift    <= 1'b0;
      r_lctrl     <= 1'b0;
      r_rctrl     <= 1'b0;
      r_lalt      <= 1'b0;
      r_ralt      <= 1'b0;
      r_caps_held <= 1'b0;
      r_caps_lock <= 1'b0;
    end else if (w_emit) begin
      if (!w_ev.ext) begin
        case (w_ev.code)
          LSHIFT: r_lshift <= ~w_ev.brk;
          RSHIFT: r_rshift <= ~w_ev.brk;
          CTRL:   r_lctrl  <= ~w_ev.brk;
          ALT:    r_lalt   <= ~w_ev.brk;
          CAPS: begin
            // Only the first make of a press toggles; typematic repeats do not.
            if (!w_ev.brk && !r_caps_held) r_caps_lock <= ~r_caps_lock;
            r_caps_held <= ~w_ev.brk;
          end
          default: ;
        endcase
      end else begin
        case (w_ev.code)
          CTRL:    r_rctrl <= ~w_ev.brk;
          ALT:     r_ralt  <= ~w_ev.brk;
          default: ;
        endcase
      end
    end
  end

  assign mods = {r_caps_lock, r_lalt | r_ralt, r_lctrl | r_rctrl, r_lshift | r_rshift};

  // ---------------- repeat filter ----------------
  logic w_push;

`ifdef PS2_REPEAT_FILTER_EN
  logic       r_last_vld;
  logic [8:0] r_last_make;
  logic       w_same_key;

  assign w_same_key = r_last_vld & (r_last_make == {w_ev.ext, w_ev.code});
  assign w_push     = w_emit & ~(~w_ev.brk & w_same_key);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_last_vld  <= 1'b0;
      r_last_make <= 9'd0;
    end else if (w_emit) begin
      if (!w_ev.brk) begin
        r_last_vld  <= 1'b1;
        r_last_make <= {w_ev.ext, w_ev.code};
      end else if (w_same_key) begin
        r_last_vld  <= 1'b0;
      end
    end
  end
`else
  assign w_push = w_emit;
`endif

  // ---------------- show-ahead event FIFO ----------------
  ps2_event_t  r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0]   r_count;
  logic          r_ovf;
  logic          w_full, w_pop, w_wr_en;
  ps2_event_t    w_head;

  assign ev_valid = (r_count != '0);
  assign w_full   = (r_count == C_FULL);
  assign w_pop    = ev_valid & ev_ready;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign w_wr_en  = w_push & (~w_full | w_pop);

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr] <= w_ev;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_wr_en) r_wr <= r_wr + 1'b1;
      if (w_pop)   r_rd <= r_rd + 1'b1;
      case ({w_wr_en, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  // Head is masked while empty so unwritten storage never reaches the port.
  assign w_head   = r_mem[r_rd];
  assign ev_code  = ev_valid ? w_head.code : 8'd0;
  assign ev_ext   = ev_valid & w_head.ext;
  assign ev_brk   = ev_valid & w_head.brk;
  assign level    = r_count;
  assign overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_ps2_event_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_ps2_event_rx                                                 |
// | Purpose  : Self-checking bench for ps2_event_rx: decoder/modifier vectors  |
// |            from a table, plus latency, error, overflow and reset sequences.|
// | Config   : honours PS2_REPEAT_FILTER_EN for repeat expectations.           |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_ps2_event_rx;

  localparam int FIFO_DEPTH     = 8;
  localparam int SYNC_STAGES    = 3;
  localparam int TIMEOUT_CYCLES = 300;
`ifdef PS2_REPEAT_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic       clk      = 1'b0;
  logic       clrn     = 1'b0;
  logic       ps2_clk  = 1'b1;
  logic       ps2_data = 1'b1;
  logic       ev_ready = 1'b0;
  logic       ev_valid, ev_ext, ev_brk, overflow, frame_err;
  logic [7:0] ev_code;
  logic [3:0] mods;
  logic [3:0] level;

  int checks = 0;
  int errors = 0;
  int n_ferr = 0;

  ps2_event_rx #(
    .FIFO_DEPTH     (FIFO_DEPTH),
    .SYNC_STAGES    (SYNC_STAGES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk       (clk),
    .clrn      (clrn),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .ev_valid  (ev_valid),
    .ev_ready  (ev_ready),
    .ev_code   (ev_code),
    .ev_ext    (ev_ext),
    .ev_brk    (ev_brk),
    .mods      (mods),
    .level     (level),
    .overflow  (overflow),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  // Counts cycles with frame_err high; a 1-cycle pulse adds exactly one.
  always @(negedge clk) if (frame_err) n_ferr++;

  typedef struct {
    int              nb;
    logic [2:0][7:0] b;
    logic            exp_ev;
    logic [9:0]      exp;
    logic [3:0]      exp_mods;
  } vec_t;

  localparam int NV = 25;
  vec_t tbl [NV];

  function automatic vec_t v(input int nb, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic e, input logic x,
                             input logic k, input logic [7:0] c, input logic [3:0] m);
    vec_t r;
    r.nb = nb; r.b[0] = b0; r.b[1] = b1; r.b[2] = b2;
    r.exp_ev = e; r.exp = {x, k, c}; r.exp_mods = m;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] mk(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

  // mode 0: plain; 1: check ev_valid latency after stop edge; 2: pop in the push cycle
  task automatic send_frame(input logic [10:0] f, input int nbits, input int mode);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      ps2_data = f[i];
      repeat (4) @(negedge clk);
      ps2_clk = 1'b0;
      if (i == 10 && mode != 0) begin
        repeat (SYNC_STAGES + 1) @(negedge clk);
        if (mode == 1) chk("lat_early", ev_valid, 0);
        if (mode == 2) ev_ready = 1'b1;
        @(negedge clk);
        ev_ready = 1'b0;
        if (mode == 1) chk("lat_valid", ev_valid, 1);
        repeat (3) @(negedge clk);
      end else begin
        repeat (8) @(negedge clk);
      end
      ps2_clk = 1'b1;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(mk(b), 11, 0);
  endtask

  task automatic pop();
    @(negedge clk);
    ev_ready = 1'b1;
    @(negedge clk);
    ev_ready = 1'b0;
  endtask

  task automatic chk_head(input string name, input logic [9:0] exp);
    chk(name, {ev_ext, ev_brk, ev_code}, exp);
  endtask

  logic [7:0]  oc [10];
  logic [10:0] bad;
  int          f0;

  initial begin
    tbl[0]  = v(2, 8'hE0, 8'h14, 8'h00, 1, 1, 0, 8'h14, 4'b0010);
    tbl[1]  = v(3, 8'hE0, 8'hF0, 8'h14, 1, 1, 1, 8'h14, 4'b0000);
    tbl[2]  = v(1, 8'h14, 8'h00, 8'h00, 1, 0, 0, 8'h14, 4'b0010);
    tbl[3]  = v(2, 8'hE0, 8'h14, 8'h00, 1, 1, 0, 8'h14, 4'b0010);
    tbl[4]  = v(3, 8'hE0, 8'hF0, 8'h14, 1, 1, 1, 8'h14, 4'b0010);
    tbl[5]  = v(2, 8'hF0, 8'h14, 8'h00, 1, 0, 1, 8'h14, 4'b0000);
    tbl[6]  = v(1, 8'h58, 8'h00, 8'h00, 1, 0, 0, 8'h58, 4'b1000);
    tbl[7]  = v(1, 8'h58, 8'h00, 8'h00, !FILT, 0, 0, 8'h58, 4'b1000);
    tbl[8]  = v(1, 8'h58, 8'h00, 8'h00, !FILT, 0, 0, 8'h58, 4'b1000);
    tbl[9]  = v(2, 8'hF0, 8'h58, 8'h00, 1, 0, 1, 8'h58, 4'b1000);
    tbl[10] = v(1, 8'h58, 8'h00, 8'h00, 1, 0, 0, 8'h58, 4'b0000);
    tbl[11] = v(2, 8'hF0, 8'h58, 8'h00, 1, 0, 1, 8'h58, 4'b0000);
    tbl[12] = v(1, 8'h12, 8'h00, 8'h00, 1, 0, 0, 8'h12, 4'b0001);
    tbl[13] = v(1, 8'h59, 8'h00, 8'h00, 1, 0, 0, 8'h59, 4'b0001);
    tbl[14] = v(2, 8'hF0, 8'h12, 8'h00, 1, 0, 1, 8'h12, 4'b0001);
    tbl[15] = v(2, 8'hF0, 8'h59, 8'h00, 1, 0, 1, 8'h59, 4'b0000);
    tbl[16] = v(1, 8'h11, 8'h00, 8'h00, 1, 0, 0, 8'h11, 4'b0100);
    tbl[17] = v(2, 8'hE0, 8'h11, 8'h00, 1, 1, 0, 8'h11, 4'b0100);
    tbl[18] = v(2, 8'hF0, 8'h11, 8'h00, 1, 0, 1, 8'h11, 4'b0100);
    tbl[19] = v(3, 8'hE0, 8'hF0, 8'h11, 1, 1, 1, 8'h11, 4'b0000);
    tbl[20] = v(1, 8'h00, 8'h00, 8'h00, 0, 0, 0, 8'h00, 4'b0000);
    tbl[21] = v(1, 8'hFF, 8'h00, 8'h00, 0, 0, 0, 8'h00, 4'b0000);
    tbl[22] = v(3, 8'hE0, 8'hE0, 8'h1C, 1, 1, 0, 8'h1C, 4'b0000);
    tbl[23] = v(3, 8'hF0, 8'hE0, 8'h1C, !FILT, 1, 0, 8'h1C, 4'b0000);
    tbl[24] = v(3, 8'hE0, 8'hF0, 8'hF0, 1, 0, 1, 8'hF0, 4'b0000);
    // last entry's third byte is a prefix; the 1C that completes it is sent below
    oc = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44, 8'h4B};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_valid", ev_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_mods", mods, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_code", ev_code, 0);
    clrn = 1'b1;
    repeat (10) @(negedge clk);

    // make / break with latency
    send_frame(mk(8'h1C), 11, 1);
    chk_head("t1_make", {2'b00, 8'h1C});
    pop();
    send_byte(8'hF0);
    chk("t1_f0_noev", level, 0);
    send_frame(mk(8'h1C), 11, 1);
    chk_head("t1_break", {2'b01, 8'h1C});
    pop();

    // table-driven decoder / modifier vectors
    for (int i = 0; i < NV; i++) begin
      for (int j = 0; j < tbl[i].nb; j++) send_byte(tbl[i].b[j]);
      if (i == NV - 1) send_byte(8'h1C);
      repeat (4) @(negedge clk);
      chk($sformatf("v%0d_mods", i), mods, tbl[i].exp_mods);
      chk($sformatf("v%0d_level", i), level, tbl[i].exp_ev ? 1 : 0);
      if (tbl[i].exp_ev) begin
        chk_head($sformatf("v%0d_ev", i), (i == NV - 1) ? {2'b01, 8'h1C} : tbl[i].exp);
        pop();
      end
    end

    // bad parity, then a stalled half frame, then a good byte
    f0 = n_ferr;
    bad = mk(8'h1C);
    bad[9] = ~bad[9];
    send_frame(bad, 11, 0);
    repeat (4) @(negedge clk);
    chk("perr_pulse", n_ferr - f0, 1);
    chk("perr_level", level, 0);
    send_frame(mk(8'h2D), 5, 0);
    repeat (TIMEOUT_CYCLES - 60) @(negedge clk);
    chk("tmo_early", n_ferr - f0, 1);
    repeat (120) @(negedge clk);
    chk("tmo_pulse", n_ferr - f0, 2);
    send_byte(8'h1C);
    repeat (4) @(negedge clk);
    chk("err_level", level, 1);
    chk_head("err_ev", {2'b00, 8'h1C});
    pop();
    send_byte(8'hF0);
    send_byte(8'h1C);
    chk_head("err_brk", {2'b01, 8'h1C});
    pop();

    // typematic repeats
    repeat (3) send_byte(8'h1C);
    repeat (4) @(negedge clk);
    chk("rep_level", level, FILT ? 1 : 3);
    for (int k = 0; k < (FILT ? 1 : 3); k++) begin
      chk_head($sformatf("rep_ev%0d", k), {2'b00, 8'h1C});
      pop();
    end
    chk("rep_empty", level, 0);

    // fill, full push+pop, overflow, drain in order
    for (int k = 0; k < FIFO_DEPTH; k++) send_byte(oc[k]);
    chk("full_level", level, FIFO_DEPTH);
    chk("full_noovf", overflow, 0);
    send_frame(mk(oc[8]), 11, 2);
    chk("pp_level", level, FIFO_DEPTH);
    chk("pp_noovf", overflow, 0);
    chk_head("pp_head", {2'b00, oc[1]});
    send_byte(oc[9]);
    chk("ovf_level", level, FIFO_DEPTH);
    chk("ovf_set", overflow, 1);
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      chk_head($sformatf("drain%0d", k), {2'b00, oc[k + 1]});
      pop();
    end
    chk("drain_empty", level, 0);
    chk("ovf_sticky", overflow, 1);

    // reset mid-prefix and mid-frame
    send_byte(8'h12);
    pop();
    chk("pre_rst_mods", mods, 4'b0001);
    send_byte(8'hE0);
    send_frame(mk(8'h22), 4, 0);
    f0 = n_ferr;
    @(negedge clk);
    clrn = 1'b0;
    @(negedge clk);
    chk("mid_rst_mods", mods, 0);
    chk("mid_rst_ovf", overflow, 0);
    chk("mid_rst_level", level, 0);
    repeat (2) @(negedge clk);
    clrn = 1'b1;
    repeat (6) @(negedge clk);
    send_byte(8'h1C);
    repeat (4) @(negedge clk);
    chk("post_rst_level", level, 1);
    chk_head("post_rst_ev", {2'b00, 8'h1C});
    chk("post_rst_ferr", n_ferr - f0, 0);
    pop();
    chk("total_ferr", n_ferr, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
